// File: rtl/axi_read_intf_pkg.sv
// Shared definitions for the AXI read interface and its address generator.
// Holds the read FSM state type, RRESP codes, burst codes and internal
// region codes, plus the address-region decode helper.
package axi_read_intf_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } state_e;

  // RRESP encodings
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  // ARBURST encodings; 2'b11 is reserved
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  // Internal target regions
  localparam logic [1:0] RegionFifo = 2'd0;
  localparam logic [1:0] RegionIram = 2'd1;
  localparam logic [1:0] RegionWram = 2'd2;

  // True when ARREGION does not map to any internal target.
  function automatic logic is_decode_err(input logic [3:0] region);
    logic known;
    known = (region[1:0] == RegionFifo) || (region[1:0] == RegionIram) ||
            (region[1:0] == RegionWram);
    return (region[3:2] != 2'b00) || !known;
  endfunction

endpackage

// File: rtl/axi_read_intf_addr_gen.sv
// axi_addr_gen: next beat address for an AXI burst.
//   addr      - current beat address
//   size      - ARSIZE/AWSIZE (log2 bytes per beat)
//   burst     - burst type
//   next_addr - address of the following beat, modulo 2^AddrWidth
// WRAP is handled like INCR; the step is clamped to the data bus width.
module axi_addr_gen
  import axi_read_intf_pkg::*;
#(
  parameter int unsigned AddrWidth = 11,
  parameter int unsigned DataWidth = 32
) (
  input  logic [AddrWidth-1:0] addr,
  input  logic [2:0]           size,
  input  logic [1:0]           burst,
  output logic [AddrWidth-1:0] next_addr
);

  localparam logic [2:0] MaxSize = 3'($clog2(DataWidth / 8));

  logic [2:0]           eff_size;
  logic [AddrWidth-1:0] step;

  always_comb begin
    eff_size = (size > MaxSize) ? MaxSize : size;
    step     = {{(AddrWidth - 1){1'b0}}, 1'b1} << eff_size;
    case (burst)
      BurstFixed: next_addr = addr;
      BurstIncr:  next_addr = addr + step;
      BurstWrap:  next_addr = addr + step;
      default:    next_addr = addr + step;
    endcase
  end

endmodule

// File: rtl/axi_read_intf.sv
// axi_read_intf: AXI read slave front end with one outstanding burst.
//   clk, rst               - clock, synchronous active-high reset
//   AR* / ARREADY          - read address channel
//   R* / RREADY            - read data channel
//   axi_rd_req/addr/region - one-cycle strobe and held beat address/target
//   rd_data/_vld/rd_err    - internal return path, sampled only in StWait
// Bad regions (DECERR) and the reserved burst type (SLVERR) are answered
// locally with zero data and never reach the internal bus.
module axi_read_intf
  import axi_read_intf_pkg::*;
#(
  parameter int unsigned ARID_WIDTH   = 8,
  parameter int unsigned ARADDR_WIDTH = 11,
  parameter int unsigned RDATA_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ARID_WIDTH-1:0]   ARID,
  input  logic [ARADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic [3:0]              ARREGION,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ARID_WIDTH-1:0]   RID,
  output logic [RDATA_WIDTH-1:0]  RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic                    axi_rd_req,
  output logic [ARADDR_WIDTH-1:0] axi_rd_addr,
  output logic [1:0]              axi_rd_region,
  input  logic [RDATA_WIDTH-1:0]  rd_data,
  input  logic                    rd_data_vld,
  input  logic                    rd_err
);

  state_e                  state_q;
  logic [7:0]              cnt_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic                    err_burst_q;
  logic [ARADDR_WIDTH-1:0] next_addr;
  logic                    dec_err;

  assign dec_err = is_decode_err(ARREGION);

  axi_addr_gen #(
    .AddrWidth(ARADDR_WIDTH),
    .DataWidth(RDATA_WIDTH)
  ) u_addr_gen (
    .addr     (axi_rd_addr),
    .size     (size_q),
    .burst    (burst_q),
    .next_addr(next_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ARREADY       <= 1'b1;
      RVALID        <= 1'b0;
      RLAST         <= 1'b0;
      RRESP         <= RespOkay;
      RDATA         <= '0;
      RID           <= '0;
      axi_rd_req    <= 1'b0;
      axi_rd_addr   <= '0;
      axi_rd_region <= '0;
      cnt_q         <= '0;
      size_q        <= '0;
      burst_q       <= '0;
      err_burst_q   <= 1'b0;
    end else begin
      axi_rd_req <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ARVALID && ARREADY) begin
            ARREADY       <= 1'b0;
            RID           <= ARID;
            axi_rd_addr   <= ARADDR;
            axi_rd_region <= ARREGION[1:0];
            cnt_q         <= ARLEN;
            size_q        <= ARSIZE;
            burst_q       <= ARBURST;
            if (dec_err || (ARBURST == 2'b11)) begin
              // Answered locally; DECERR wins over SLVERR.
              err_burst_q <= 1'b1;
              state_q     <= StResp;
              RVALID      <= 1'b1;
              RDATA       <= '0;
              RLAST       <= (ARLEN == 8'd0);
              RRESP       <= dec_err ? RespDecerr : RespSlverr;
            end else begin
              err_burst_q <= 1'b0;
              state_q     <= StReq;
              axi_rd_req  <= 1'b1;
            end
          end
        end
        StReq: state_q <= StWait;
        StWait: begin
          if (rd_data_vld) begin
            RDATA   <= rd_data;
            RRESP   <= rd_err ? RespSlverr : RespOkay;
            RVALID  <= 1'b1;
            RLAST   <= (cnt_q == 8'd0);
            state_q <= StResp;
          end
        end
        StResp: begin
          if (RREADY) begin
            if (RLAST) begin
              RVALID  <= 1'b0;
              RLAST   <= 1'b0;
              ARREADY <= 1'b1;
              state_q <= StIdle;
            end else begin
              cnt_q       <= cnt_q - 8'd1;
              axi_rd_addr <= next_addr;
              if (err_burst_q) begin
                // Error beats are back to back; counter reaches 0 on this edge.
                RLAST <= (cnt_q == 8'd1);
              end else begin
                RVALID     <= 1'b0;
                state_q    <= StReq;
                axi_rd_req <= 1'b1;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_intf.sv
module tb_axi_read_intf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ARID = '0;
  logic [10:0] ARADDR = '0;
  logic [7:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = '0;
  logic [1:0]  ARBURST = '0;
  logic [3:0]  ARREGION = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b1;
  logic        axi_rd_req;
  logic [10:0] axi_rd_addr;
  logic [1:0]  axi_rd_region;
  logic [31:0] rd_data = '0;
  logic        rd_data_vld = 1'b0;
  logic        rd_err = 1'b0;

  axi_read_intf #(
    .ARID_WIDTH  (8),
    .ARADDR_WIDTH(11),
    .RDATA_WIDTH (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ARID         (ARID),
    .ARADDR       (ARADDR),
    .ARLEN        (ARLEN),
    .ARSIZE       (ARSIZE),
    .ARBURST      (ARBURST),
    .ARREGION     (ARREGION),
    .ARVALID      (ARVALID),
    .ARREADY      (ARREADY),
    .RID          (RID),
    .RDATA        (RDATA),
    .RRESP        (RRESP),
    .RLAST        (RLAST),
    .RVALID       (RVALID),
    .RREADY       (RREADY),
    .axi_rd_req   (axi_rd_req),
    .axi_rd_addr  (axi_rd_addr),
    .axi_rd_region(axi_rd_region),
    .rd_data      (rd_data),
    .rd_data_vld  (rd_data_vld),
    .rd_err       (rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  typedef struct {
    logic [10:0] addr;
    logic [1:0]  region;
  } req_t;

  beat_t sb_q[$];
  req_t  req_q[$];
  beat_t mon_b;
  req_t  mon_r;

  int checks = 0;
  int errors = 0;
  int n_req = 0;
  int total_beats = 0;
  int base = 0;
  int cur_len = 0;
  int rsp_bi = 0;
  int resp_delay = 0;
  bit discard = 1'b0;
  logic [7:0] cur_id = '0;
  logic [7:0] err_plan = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: internal requests and R beats against the scoreboards.
  always @(negedge clk) begin
    if (!rst && axi_rd_req) begin
      n_req++;
      check("req_expected", 64'(req_q.size() > 0), 64'(1));
      if (req_q.size() > 0) begin
        mon_r = req_q.pop_front();
        check("rd_addr", 64'(axi_rd_addr), 64'(mon_r.addr));
        check("rd_region", 64'(axi_rd_region), 64'(mon_r.region));
      end
    end
    if (!rst && RVALID && RREADY) begin
      check("beat_expected", 64'(sb_q.size() > 0), 64'(1));
      if (sb_q.size() > 0) begin
        mon_b = sb_q.pop_front();
        check("rid", 64'(RID), 64'(mon_b.id));
        check("rdata", 64'(RDATA), 64'(mon_b.data));
        check("rresp", 64'(RRESP), 64'(mon_b.resp));
        check("rlast", 64'(RLAST), 64'(mon_b.last));
      end
    end
  end

  // Internal memory model: answers each request after 1 + resp_delay cycles.
  always @(negedge clk) begin
    if (!rst && axi_rd_req) begin
      @(posedge clk);
      repeat (resp_delay) @(posedge clk);
      #1;
      rsp_bi      = total_beats - base;
      rd_data     = $urandom();
      rd_err      = err_plan[rsp_bi[2:0]];
      rd_data_vld = 1'b1;
      if (!discard) begin
        sb_q.push_back('{cur_id, rd_data, (rd_err ? 2'b10 : 2'b00), (rsp_bi == cur_len)});
        total_beats++;
      end
      @(posedge clk);
      #1;
      rd_data_vld = 1'b0;
      rd_err      = 1'b0;
    end
  end

  // Loads the expectation model, then performs the AR handshake; returns at
  // the negedge of the cycle after the handshake.
  task automatic issue_ar(input logic [7:0] id, input logic [10:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [3:0] region, input logic [7:0] errs,
                          output int n0, output int exp_reqs);
    logic [10:0] a;
    bit dec;
    bit slv;
    int sh;
    int k;
    a        = addr;
    dec      = (region[3:2] != 2'b00) || (region[1:0] == 2'b11);
    slv      = (burst == 2'b11);
    sh       = (size > 3'd2) ? 2 : int'(size);
    cur_id   = id;
    err_plan = errs;
    cur_len  = int'(len);
    base     = total_beats;
    n0       = n_req;
    exp_reqs = (dec || slv) ? 0 : int'(len) + 1;
    for (int i = 0; i <= int'(len); i++) begin
      if (dec || slv) begin
        sb_q.push_back('{id, 32'h0, (dec ? 2'b11 : 2'b10), (i == int'(len))});
      end else begin
        req_q.push_back('{a, region[1:0]});
        if (burst != 2'b00) a = a + 11'(1 << sh);
      end
    end
    @(posedge clk);
    #1;
    ARID     = id;
    ARADDR   = addr;
    ARLEN    = len;
    ARSIZE   = size;
    ARBURST  = burst;
    ARREGION = region;
    ARVALID  = 1'b1;
    @(negedge clk);
    k = 0;
    while (!ARREADY && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ar_accept", 64'(ARREADY), 64'(1));
    @(posedge clk);
    #1;
    ARVALID = 1'b0;
    @(negedge clk);
    check("arready_busy", 64'(ARREADY), 64'(0));
    if (dec || slv) begin
      check("err_no_req", 64'(axi_rd_req), 64'(0));
      check("err_rvalid", 64'(RVALID), 64'(1));
    end else begin
      check("req_latency", 64'(axi_rd_req), 64'(1));
    end
  endtask

  task automatic wait_done(input string tag, input int n0, input int exp_reqs);
    int k;
    bit done;
    k    = 0;
    done = 1'b0;
    while (!done && k < 300) begin
      @(negedge clk);
      done = ARREADY && (sb_q.size() == 0) && (req_q.size() == 0);
      k++;
    end
    check({tag, "_done"}, 64'(done), 64'(1));
    check({tag, "_reqs"}, 64'(n_req - n0), 64'(exp_reqs));
    if (!done) begin
      sb_q.delete();
      req_q.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n0;
    int er;
    int k;
    logic [31:0] held;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", 64'(ARREADY), 64'(1));
    check("rst_rvalid", 64'(RVALID), 64'(0));
    check("rst_rlast", 64'(RLAST), 64'(0));
    check("rst_rresp", 64'(RRESP), 64'(0));
    check("rst_rdata", 64'(RDATA), 64'(0));
    check("rst_rid", 64'(RID), 64'(0));
    check("rst_req", 64'(axi_rd_req), 64'(0));
    check("rst_addr", 64'(axi_rd_addr), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // INCR, 4 beats from 0x010
    issue_ar(8'hA5, 11'h010, 8'd3, 3'd2, 2'b01, 4'd1, 8'h00, n0, er);
    wait_done("incr", n0, er);

    // FIXED with RREADY held low on the first beat
    RREADY = 1'b0;
    issue_ar(8'h3C, 11'h123, 8'd2, 3'd0, 2'b00, 4'd2, 8'h00, n0, er);
    k = 0;
    while (!RVALID && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("bp_rvalid_seen", 64'(RVALID), 64'(1));
    held = (sb_q.size() > 0) ? sb_q[0].data : 32'h0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_rvalid_hold", 64'(RVALID), 64'(1));
      check("bp_rdata_hold", 64'(RDATA), 64'(held));
      check("bp_no_req", 64'(axi_rd_req), 64'(0));
    end
    @(posedge clk);
    #1;
    RREADY = 1'b1;
    wait_done("fixed", n0, er);

    // Unmapped region -> DECERR
    issue_ar(8'h11, 11'h200, 8'd1, 3'd2, 2'b01, 4'd3, 8'h00, n0, er);
    wait_done("decerr", n0, er);

    // Reserved burst -> SLVERR
    issue_ar(8'h22, 11'h300, 8'd2, 3'd2, 2'b11, 4'd0, 8'h00, n0, er);
    wait_done("slverr", n0, er);

    // Both faults: DECERR wins, single beat
    issue_ar(8'h33, 11'h000, 8'd0, 3'd2, 2'b11, 4'b0100, 8'h00, n0, er);
    wait_done("prio", n0, er);

    // rd_err on the middle beat
    issue_ar(8'h44, 11'h080, 8'd2, 3'd2, 2'b01, 4'd0, 8'b0000_0010, n0, er);
    wait_done("rderr", n0, er);

    // Address wraps past the top of the space
    issue_ar(8'h55, 11'h7FC, 8'd1, 3'd2, 2'b01, 4'd1, 8'h00, n0, er);
    wait_done("wrap", n0, er);

    // Oversized beat on a WRAP burst steps by the bus width
    issue_ar(8'h66, 11'h100, 8'd2, 3'd3, 2'b10, 4'd2, 8'h00, n0, er);
    wait_done("clamp", n0, er);

    // Reset while waiting for internal data; the late return must vanish
    resp_delay = 2;
    discard    = 1'b1;
    issue_ar(8'h5A, 11'h040, 8'd1, 3'd2, 2'b01, 4'd1, 8'h00, n0, er);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_rvalid", 64'(RVALID), 64'(0));
    check("mid_rst_arready", 64'(ARREADY), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("late_vld_ignored", 64'(RVALID), 64'(0));
    end
    req_q.delete();
    resp_delay = 0;
    discard    = 1'b0;

    // Normal single-beat burst after reset
    issue_ar(8'h77, 11'h020, 8'd0, 3'd2, 2'b01, 4'd1, 8'h00, n0, er);
    wait_done("post_rst", n0, er);

    check("sb_empty", 64'(sb_q.size()), 64'(0));
    check("req_q_empty", 64'(req_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_read_intf.md
AXI_READ_INTF -- requirements
Module: axi_read_intf

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports are named clk and rst.
REQ-002 Parameter ARID_WIDTH, default 8: width of ARID and RID.
REQ-003 Parameter ARADDR_WIDTH, default 11: byte address width.
REQ-004 Parameter RDATA_WIDTH, default 32: data width.
REQ-005 Ports SHALL be, in order (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, sync active-high reset.
- ARID, in, ARID_WIDTH, transaction ID.
- ARADDR, in, ARADDR_WIDTH, start byte address.
- ARLEN, in, 8, beats minus 1.
- ARSIZE, in, 3, log2 bytes per beat.
- ARBURST, in, 2, burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- ARREGION, in, 4, target region.
- ARVALID, in, 1, address valid.
- ARREADY, out, 1, address accept.
- RID, out, ARID_WIDTH, echoed ID.
- RDATA, out, RDATA_WIDTH, read data.
- RRESP, out, 2, response: 00 OKAY, 10 SLVERR, 11 DECERR.
- RLAST, out, 1, final beat.
- RVALID, out, 1, data valid.
- RREADY, in, 1, master accept.
- axi_rd_req, out, 1, one-cycle internal read strobe.
- axi_rd_addr, out, ARADDR_WIDTH, internal beat address.
- axi_rd_region, out, 2, 0 fifo, 1 iram, 2 wram.
- rd_data, in, RDATA_WIDTH, internal return data.
- rd_data_vld, in, 1, return data valid.
- rd_err, in, 1, error flag qualified by rd_data_vld.

Function
REQ-006 The block SHALL support one outstanding burst; the FSM states are IDLE, REQ, WAIT, RESP.
REQ-007 ARREADY SHALL be 1 only in IDLE; a handshake (ARVALID&ARREADY) SHALL capture ARID, ARADDR, ARLEN, ARSIZE, ARBURST and ARREGION, and load the beat counter with ARLEN.
REQ-008 Decode error: if ARREGION[3:2]!=0 or ARREGION[1:0]==3, the block SHALL go IDLE->RESP with no internal requests and return ARLEN+1 beats with RRESP=DECERR and RDATA=0; otherwise it SHALL go IDLE->REQ.
REQ-009 If ARBURST=11, the block SHALL return ARLEN+1 beats with RRESP=SLVERR and RDATA=0, with no internal requests; DECERR takes priority over SLVERR.
REQ-010 REQ SHALL last exactly one cycle with axi_rd_req=1, then go to WAIT; axi_rd_addr and axi_rd_region SHALL hold stable from REQ until rd_data_vld.
REQ-011 In WAIT, rd_data_vld SHALL capture rd_data into RDATA and set RRESP to SLVERR if rd_err=1, else OKAY; the FSM SHALL go to RESP and RVALID=1 the next cycle. rd_data_vld outside WAIT SHALL be ignored.
REQ-012 In RESP, RVALID, RDATA, RRESP, RID and RLAST SHALL hold until RREADY; RLAST=1 exactly when the beat counter is 0.
REQ-013 On RVALID&RREADY: if RLAST, go to IDLE with ARREADY=1 in the next cycle; else decrement the counter, advance the address, and go to REQ (or stay in RESP for error bursts).
REQ-014 Address advance:
- FIXED: unchanged.
- INCR and WRAP (WRAP treated as INCR): add 1<<min(ARSIZE,log2(RDATA_WIDTH/8)).
- Overflow wraps modulo 2^ARADDR_WIDTH.
REQ-015 Minimum latency SHALL be: AR handshake in cycle T, axi_rd_req in T+1, rd_data_vld in T+2, RVALID in T+3; each later beat adds 1 cycle after RREADY before REQ.
REQ-016 ARLEN=0 SHALL produce a single beat with RLAST=1.

Reset
REQ-017 While rst=1 at a clock edge, the block SHALL set: state IDLE, ARREADY=1 after the edge, RVALID=0, RLAST=0, RRESP=00, RDATA=0, RID=0, axi_rd_req=0, address and counter 0.
REQ-018 Reset mid-burst SHALL abandon all pending beats; a rd_data_vld arriving after reset SHALL be ignored.

Structure
REQ-019 A shared package SHALL hold the FSM state enum, the RRESP codes (OKAY, SLVERR, DECERR), the burst codes (FIXED, INCR, WRAP) and the region codes.
REQ-020 Next-address computation SHALL live in the sub-module axi_addr_gen (inputs: addr, size, burst; output: next addr); the same module is reusable by the write path.

Verification
REQ-021 INCR burst: ARADDR=0x010, ARLEN=3, ARSIZE=2, region 1, RREADY=1, rd_data_vld 1 cycle after each request -> axi_rd_addr 0x010, 0x014, 0x018, 0x01C; 4 beats OKAY; RLAST on the 4th; RID echoes ARID.
REQ-022 FIXED burst: ARLEN=2, ARSIZE=0 -> 3 requests all to ARADDR; backpressure with RREADY low for 3 cycles -> RVALID and RDATA held stable, no new axi_rd_req.
REQ-023 Bad target: ARREGION=3, ARLEN=1 -> no axi_rd_req, 2 beats DECERR, RDATA=0; a separate ARBURST=11 burst -> SLVERR beats.
REQ-024 rd_err=1 on beat 2 of 3 -> RRESP OKAY, SLVERR, OKAY; INCR burst from address 0x7FC with ARSIZE=2 -> next address 0x000.
REQ-025 rst asserted in WAIT -> the next cycle shows RVALID=0 and ARREADY=1; a late rd_data_vld produces no R beat; a new burst completes normally.
